// File: rtl/rv32i_multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences fetch/decode/exec/mem/writeback on a shared
// datapath, counts retired instructions and traps on illegal/system opcodes or memory stalls.
module rv32i_multicycle_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret,
    output logic             trap,
    output logic [1:0]       trap_cause
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    state_t          st, st_nx;
    logic [1:0]      cause_nx;
    logic            retire, mem_wait, to_hit;
    logic [TO_W-1:0] to_cnt;
    logic            is_lui, is_auipc, is_jal, is_jalr, is_branch;
    logic            is_load, is_store, is_opimm, is_op, is_fence, is_system, is_legal;
    logic            unused_funct3;

    // Decoding is by major opcode only; funct3/funct7 are the ALU's business.
    assign unused_funct3 = ^funct3;
    assign is_lui    = (opcode == OPC_LUI);
    assign is_auipc  = (opcode == OPC_AUIPC);
    assign is_jal    = (opcode == OPC_JAL);
    assign is_jalr   = (opcode == OPC_JALR);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_opimm  = (opcode == OPC_OPIMM);
    assign is_op     = (opcode == OPC_OP);
    assign is_fence  = (opcode == OPC_FENCE);
    assign is_system = (opcode == OPC_SYSTEM);
    assign is_legal  = is_lui | is_auipc | is_jal | is_jalr | is_branch |
                       is_load | is_store | is_opimm | is_op | is_fence;

    assign to_hit = (MEM_TIMEOUT != 0) && (to_cnt == TO_LAST);
    assign state  = st;

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 1'b0;
        reg_we    = 1'b0;
        wb_sel    = 2'd0;
        alu_src_a = 2'd0;
        alu_src_b = 2'd0;
        alu_op    = 2'd0;
        retire    = 1'b0;
        mem_wait  = 1'b0;
        cause_nx  = 2'd0;
        st_nx     = st;
        case (st)
            S_IDLE: if (en) st_nx = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
                if (mem_ready) st_nx = S_DECODE;
                else           mem_wait = 1'b1;
            end
            S_DECODE: begin
                // Branch compare runs here so EXEC can reuse the ALU for the target.
                if (is_branch) alu_op = 2'd1;
                if (is_system) begin
                    st_nx    = S_TRAP;
                    cause_nx = 2'd2;
                end else if (!is_legal) begin
                    st_nx    = S_TRAP;
                    cause_nx = 2'd1;
                end else begin
                    st_nx = S_EXEC;
                end
            end
            S_EXEC: begin
                st_nx = S_WB;
                if (is_load || is_store) begin
                    alu_src_b = 2'd1;
                    st_nx     = S_MEM;
                end else if (is_op) begin
                    alu_op = 2'd2;
                end else if (is_opimm) begin
                    alu_src_b = 2'd1;
                    alu_op    = 2'd2;
                end else if (is_lui) begin
                    alu_src_a = 2'd2;
                    alu_src_b = 2'd1;
                end else if (is_auipc || is_jal) begin
                    alu_src_a = 2'd1;
                    alu_src_b = 2'd1;
                end else if (is_jalr) begin
                    alu_src_b = 2'd1;
                end else if (is_branch) begin
                    alu_src_a = 2'd1;
                    alu_src_b = 2'd1;
                    pc_we     = 1'b1;
                    pc_sel    = branch_taken;
                    retire    = 1'b1;
                end else if (is_fence) begin
                    pc_we  = 1'b1;
                    retire = 1'b1;
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = is_store;
                if (!mem_ready) begin
                    mem_wait = 1'b1;
                end else if (is_store) begin
                    pc_we  = 1'b1;
                    retire = 1'b1;
                end else begin
                    st_nx = S_WB;
                end
            end
            S_WB: begin
                reg_we = 1'b1;
                pc_we  = 1'b1;
                retire = 1'b1;
                if (is_load) begin
                    wb_sel = 2'd1;
                end else if (is_jal || is_jalr) begin
                    wb_sel = 2'd2;
                    pc_sel = 1'b1;
                end
            end
            default: ;
        endcase
        if (retire) st_nx = en ? S_FETCH : S_IDLE;
        if (mem_wait && to_hit) begin
            st_nx    = S_TRAP;
            cause_nx = 2'd3;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st         <= S_IDLE;
            instret    <= '0;
            trap       <= 1'b0;
            trap_cause <= 2'd0;
            to_cnt     <= '0;
        end else begin
            st <= st_nx;
            if (retire) instret <= instret + CNT_W'(1);
            if (st_nx == S_TRAP && st != S_TRAP) begin
                trap       <= 1'b1;
                trap_cause <= cause_nx;
            end
            // Stall counter restarts on any state change or completed handshake.
            to_cnt <= (mem_wait && st_nx == st) ? to_cnt + TO_W'(1) : '0;
        end
    end

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Bench for rv32i_multicycle_ctrl: directed corner sequences, a per-opcode vector table and
// randomized instruction streams checked against an instruction-level expectation model.
module tb_rv32i_multicycle_ctrl;

    localparam int CNT_W = 4;

    logic             clk, rst, en, branch_taken, mem_ready;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, reg_we, trap;
    logic [1:0]       wb_sel, alu_src_a, alu_src_b, alu_op, trap_cause;
    logic [2:0]       state;
    logic [CNT_W-1:0] instret;
    logic [14:0]      strb;

    int checks = 0;
    int failures = 0;
    int exp_instret = 0;

    rv32i_multicycle_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .en(en), .opcode(opcode), .funct3(funct3),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we),
        .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we), .wb_sel(wb_sel),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .state(state), .instret(instret), .trap(trap), .trap_cause(trap_cause)
    );

    assign strb = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, reg_we,
                   wb_sel, alu_src_a, alu_src_b, alu_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [6:0] opc;
        logic       bt;
        int         lat;
        int         nmem;
        int         nst;
        int         nreg;
        logic [1:0] wb;
        logic       pcs;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] op;
        bit         alu_ck;
        bit         op_ck;
    } vec_t;

    vec_t tbl[11];
    logic [6:0] legal_ops[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic go_pos();
        @(posedge clk);
        #1;
    endtask

    // Instruction-level expectations derived from each opcode's class.
    function automatic vec_t model(input logic [6:0] opc, input logic bt);
        vec_t v;
        v = '{default: 0};
        v.opc = opc; v.bt = bt; v.lat = 4; v.nmem = 1; v.nreg = 1; v.alu_ck = 1'b1;
        case (opc)
            7'b0000011: begin v.lat = 5; v.nmem = 2; v.wb = 2'd1; v.b = 2'd1; v.op_ck = 1'b1; end
            7'b0100011: begin v.nmem = 2; v.nst = 1; v.nreg = 0; v.b = 2'd1; v.op_ck = 1'b1; end
            7'b0110011: begin v.op = 2'd2; v.op_ck = 1'b1; end
            7'b0010011: begin v.b = 2'd1; v.op = 2'd2; v.op_ck = 1'b1; end
            7'b0110111: begin v.a = 2'd2; v.b = 2'd1; end
            7'b0010111: begin v.a = 2'd1; v.b = 2'd1; end
            7'b1101111: begin v.a = 2'd1; v.b = 2'd1; v.wb = 2'd2; v.pcs = 1'b1; end
            7'b1100111: begin v.b = 2'd1; v.wb = 2'd2; v.pcs = 1'b1; end
            7'b1100011: begin v.lat = 3; v.nreg = 0; v.a = 2'd1; v.b = 2'd1; v.pcs = bt; end
            default:    begin v.lat = 3; v.nreg = 0; v.alu_ck = 1'b0; end
        endcase
        return v;
    endfunction

    task automatic do_reset();
        rst = 1'b0; en = 1'b0; mem_ready = 1'b0; opcode = 7'd0; branch_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_instret", 32'(instret), 32'd0);
        check("rst_trap", 32'({trap, trap_cause}), 32'd0);
        check("rst_strobes", 32'(strb), 32'd0);
        rst = 1'b1;
        exp_instret = 0;
    endtask

    // Runs one instruction starting in FETCH; returns once it retires (bounded).
    task automatic run_instr(input vec_t v, input bit rnd);
        int lat = 0, nmem = 0, nst = 0, nreg = 0, stalls = 0, consec = 0;
        logic [1:0] wb = 2'd3;
        logic pcs = 1'bx;
        logic [5:0] alu = 6'h3f;
        bit retired = 1'b0;
        opcode = v.opc;
        branch_taken = v.bt;
        for (int c = 0; c < 80 && !retired; c++) begin
            mem_ready = rnd ? (($urandom_range(0, 3) != 0) || consec >= 6) : 1'b1;
            consec = mem_ready ? 0 : consec + 1;
            @(negedge clk);
            lat++;
            if (mem_req && !mem_ready) stalls++;
            if (mem_req && mem_ready) nmem++;
            if (mem_req && mem_we && mem_ready) nst++;
            if (reg_we) begin nreg++; wb = wb_sel; end
            if (state == 3'd3) alu = {alu_src_a, alu_src_b, alu_op};
            if (pc_we) begin retired = 1'b1; pcs = pc_sel; end
            go_pos();
        end
        exp_instret++;
        check($sformatf("retired_%b", v.opc), 32'(retired), 32'd1);
        check($sformatf("latency_%b", v.opc), 32'(lat - stalls), 32'(v.lat));
        check($sformatf("mem_xfers_%b", v.opc), 32'(nmem), 32'(v.nmem));
        check($sformatf("stores_%b", v.opc), 32'(nst), 32'(v.nst));
        check($sformatf("reg_writes_%b", v.opc), 32'(nreg), 32'(v.nreg));
        if (v.nreg != 0) check($sformatf("wb_sel_%b", v.opc), 32'(wb), 32'(v.wb));
        check($sformatf("pc_sel_%b", v.opc), 32'(pcs), 32'(v.pcs));
        if (v.alu_ck) check($sformatf("alu_ab_%b", v.opc), 32'(alu[5:2]), 32'({v.a, v.b}));
        if (v.op_ck) check($sformatf("alu_op_%b", v.opc), 32'(alu[1:0]), 32'(v.op));
        check("instret", 32'(instret), 32'(exp_instret % (1 << CNT_W)));
        check("next_fetch", 32'(state), 32'd1);
    endtask

    task automatic count_wait(input logic [2:0] st, output int n);
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (state == 3'd7) break;
            if (state == st && mem_req) n++;
            go_pos();
        end
    endtask

    int exp_st[5];
    int n;
    vec_t v;

    initial begin
        funct3 = 3'd0;
        exp_st = '{0, 1, 2, 3, 5};
        legal_ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                      7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111};
        //             opc         bt lat mem st reg wb pcs a  b  op alu op
        tbl[0]  = '{7'b0110011, 0, 4, 1, 0, 1, 0, 0, 0, 0, 2, 1, 1};
        tbl[1]  = '{7'b0010011, 0, 4, 1, 0, 1, 0, 0, 0, 1, 2, 1, 1};
        tbl[2]  = '{7'b0110111, 0, 4, 1, 0, 1, 0, 0, 2, 1, 0, 1, 0};
        tbl[3]  = '{7'b0010111, 0, 4, 1, 0, 1, 0, 0, 1, 1, 0, 1, 0};
        tbl[4]  = '{7'b1101111, 0, 4, 1, 0, 1, 2, 1, 1, 1, 0, 1, 0};
        tbl[5]  = '{7'b1100111, 0, 4, 1, 0, 1, 2, 1, 0, 1, 0, 1, 0};
        tbl[6]  = '{7'b0000011, 0, 5, 2, 0, 1, 1, 0, 0, 1, 0, 1, 1};
        tbl[7]  = '{7'b0100011, 0, 4, 2, 1, 0, 0, 0, 0, 1, 0, 1, 1};
        tbl[8]  = '{7'b1100011, 1, 3, 1, 0, 0, 0, 1, 1, 1, 0, 1, 0};
        tbl[9]  = '{7'b1100011, 0, 3, 1, 0, 0, 0, 0, 1, 1, 0, 1, 0};
        tbl[10] = '{7'b0001111, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        // OP right after reset: IDLE, FETCH, DECODE, EXEC, WB
        do_reset();
        en = 1'b1; mem_ready = 1'b1; opcode = 7'b0110011;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("op_state_c%0d", i), 32'(state), 32'(exp_st[i]));
            go_pos();
        end
        check("op_instret", 32'(instret), 32'd1);

        // LOAD with three stall cycles in MEM
        do_reset();
        en = 1'b1; mem_ready = 1'b1; opcode = 7'b0000011;
        repeat (4) go_pos();
        mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) mem_ready = 1'b1;
            @(negedge clk);
            check($sformatf("ld_mem_k%0d", k), 32'({state, mem_req, mem_we, addr_sel}), 32'({3'd4, 3'b101}));
            go_pos();
        end
        @(negedge clk);
        check("ld_wb", 32'({state, reg_we, wb_sel, pc_we}), 32'({3'd5, 1'b1, 2'd1, 1'b1}));
        go_pos();
        check("ld_instret", 32'(instret), 32'd1);

        // illegal opcode traps and stays quiet until reset
        do_reset();
        en = 1'b1; mem_ready = 1'b1; opcode = 7'b1111111;
        repeat (3) go_pos();
        @(negedge clk);
        check("ill_trap", 32'({state, trap, trap_cause}), 32'({3'd7, 1'b1, 2'd1}));
        for (int k = 0; k < 10; k++) begin
            go_pos();
            @(negedge clk);
            check($sformatf("ill_quiet_%0d", k), 32'({state, strb}), 32'({3'd7, 15'd0}));
        end
        check("ill_instret", 32'(instret), 32'd0);
        rst = 1'b0;
        #1;
        check("ill_async_rst", 32'({state, trap, trap_cause}), 32'd0);

        // SYSTEM opcode
        do_reset();
        en = 1'b1; mem_ready = 1'b1; opcode = 7'b1110011;
        repeat (3) go_pos();
        check("sys_trap", 32'({state, trap, trap_cause}), 32'({3'd7, 1'b1, 2'd2}));

        // FETCH timeout
        do_reset();
        en = 1'b1; mem_ready = 1'b0;
        go_pos();
        count_wait(3'd1, n);
        check("fetch_to_waits", 32'(n), 32'd16);
        check("fetch_to_trap", 32'({state, trap, trap_cause, mem_req}), 32'({3'd7, 1'b1, 2'd3, 1'b0}));
        check("fetch_to_instret", 32'(instret), 32'd0);

        // MEM timeout on a store
        do_reset();
        en = 1'b1; mem_ready = 1'b1; opcode = 7'b0100011;
        repeat (4) go_pos();
        mem_ready = 1'b0;
        count_wait(3'd4, n);
        check("mem_to_waits", 32'(n), 32'd16);
        check("mem_to_trap", 32'({state, trap_cause, mem_req, pc_we}), 32'({3'd7, 2'd3, 2'b00}));

        // en dropped during JAL EXEC
        do_reset();
        en = 1'b1; mem_ready = 1'b1; opcode = 7'b1101111;
        repeat (3) go_pos();
        en = 1'b0;
        @(negedge clk);
        check("jal_exec", 32'(state), 32'd3);
        go_pos();
        @(negedge clk);
        check("jal_wb", 32'({state, wb_sel, pc_sel, reg_we}), 32'({3'd5, 2'd2, 1'b1, 1'b1}));
        go_pos();
        check("jal_idle", 32'(state), 32'd0);
        go_pos();
        check("jal_idle_hold", 32'(state), 32'd0);
        en = 1'b1;
        go_pos();
        check("jal_refetch", 32'({state, instret}), 32'({3'd1, 4'd1}));

        // reset in the middle of an instruction
        do_reset();
        en = 1'b1; mem_ready = 1'b1; opcode = 7'b0110011;
        repeat (5) go_pos();
        check("mid_pre_instret", 32'(instret), 32'd1);
        repeat (2) go_pos();
        #2 rst = 1'b0;
        #1;
        check("mid_rst", 32'({state, instret, strb}), 32'd0);
        go_pos();
        check("mid_rst_hold", 32'(state), 32'd0);

        // vector table, then randomized stream (counter wraps at 16)
        do_reset();
        en = 1'b1;
        go_pos();
        for (int i = 0; i < 11; i++) run_instr(tbl[i], 1'b0);
        for (int i = 0; i < 40; i++) begin
            v = model(legal_ops[$urandom_range(0, 9)], 1'($urandom_range(0, 1)));
            run_instr(v, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
